pixel_filter_engine: RTL

Frame-level colour filter for the image-processing pipeline. Reads NUM_PIXELS RGB pixels from three single-port read memories, one pixel per cycle. Applies a run-time-selectable filter (pass-through, grayscale, sepia, invert) in a fixed-latency pipeline. Emits results on a valid/ready stream with per-pixel address tag and a frame-done pulse. Supersedes the single-pixel, sepia-only wrapper: adds channel width, frame size, mode selection, backpressure and frame sequencing.

---
 rtl/pixel_filter_pkg.sv | 41 ++++
 rtl/pixel_filter_math.sv | 106 ++++++++++
 rtl/pixel_filter_engine.sv | 130 +++++++++++++
 3 files changed

// File: rtl/pixel_filter_pkg.sv
// Shared types and Q0.8 coefficients for the pixel filter engine.
package pixel_filter_pkg;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'd0,
    MODE_GRAY   = 2'd1,
    MODE_SEPIA  = 2'd2,
    MODE_INVERT = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int unsigned FRAC_W   = 8;
  localparam int unsigned NUM_COEF = 12;

  localparam int unsigned C_SEP_RR = 101;
  localparam int unsigned C_SEP_RG = 197;
  localparam int unsigned C_SEP_RB = 48;
  localparam int unsigned C_SEP_GR = 89;
  localparam int unsigned C_SEP_GG = 176;
  localparam int unsigned C_SEP_GB = 43;
  localparam int unsigned C_SEP_BR = 70;
  localparam int unsigned C_SEP_BG = 137;
  localparam int unsigned C_SEP_BB = 34;
  localparam int unsigned C_GRAY_R = 77;
  localparam int unsigned C_GRAY_G = 150;
  localparam int unsigned C_GRAY_B = 29;

  // Grouped by output term; each group of three multiplies R, G, B in order.
  localparam int unsigned COEF_TAB [NUM_COEF] = '{
    C_SEP_RR, C_SEP_RG, C_SEP_RB,
    C_SEP_GR, C_SEP_GG, C_SEP_GB,
    C_SEP_BR, C_SEP_BG, C_SEP_BB,
    C_GRAY_R, C_GRAY_G, C_GRAY_B
  };

endpackage

// File: rtl/pixel_filter_math.sv
// Pipeline stages S2 (products) and S3 (sum, shift, saturate, mode select).
module pixel_filter_math
  import pixel_filter_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned COEF_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_en,
  input  logic              i_s2_vld,
  input  mode_e             i_mode,
  input  logic [DATA_W-1:0] i_r,
  input  logic [DATA_W-1:0] i_g,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_r,
  output logic [DATA_W-1:0] o_g,
  output logic [DATA_W-1:0] o_b
);

  localparam int unsigned PROD_W = DATA_W + COEF_W;
  localparam int unsigned SUM_W  = PROD_W + 2;
  localparam logic [SUM_W-1:0] SAT_MAX = SUM_W'((2 ** DATA_W) - 1);

  logic [PROD_W-1:0] w_prod [NUM_COEF];
  logic [PROD_W-1:0] r_prod [NUM_COEF];
  logic [DATA_W-1:0] r_r2, r_g2, r_b2;
  logic [SUM_W-1:0]  w_sum [4];
  logic [DATA_W-1:0] w_r, w_g, w_b;

  function automatic logic [DATA_W-1:0] sat(input logic [SUM_W-1:0] s);
    logic [SUM_W-1:0] q;
    q = s >> FRAC_W;
    if (q > SAT_MAX) return '1;
    return DATA_W'(q);
  endfunction

  // Full-width products of every coefficient against its channel.
  always_comb begin
    for (int i = 0; i < int'(NUM_COEF); i++) begin
      case (i % 3)
        0:       w_prod[i] = PROD_W'(i_r) * PROD_W'(COEF_TAB[i]);
        1:       w_prod[i] = PROD_W'(i_g) * PROD_W'(COEF_TAB[i]);
        default: w_prod[i] = PROD_W'(i_b) * PROD_W'(COEF_TAB[i]);
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_COEF); i++) r_prod[i] <= '0;
      r_r2 <= '0;
      r_g2 <= '0;
      r_b2 <= '0;
    end else if (i_en) begin
      for (int i = 0; i < int'(NUM_COEF); i++) r_prod[i] <= w_prod[i];
      r_r2 <= i_r;
      r_g2 <= i_g;
      r_b2 <= i_b;
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_sum[k] = SUM_W'(r_prod[3*k]) + SUM_W'(r_prod[3*k+1]) + SUM_W'(r_prod[3*k+2]);
    end
  end

  always_comb begin
    w_r = r_r2;
    w_g = r_g2;
    w_b = r_b2;
    unique case (i_mode)
      MODE_PASS: ;
      MODE_GRAY: begin
        w_r = sat(w_sum[3]);
        w_g = sat(w_sum[3]);
        w_b = sat(w_sum[3]);
      end
      MODE_SEPIA: begin
        w_r = sat(w_sum[0]);
        w_g = sat(w_sum[1]);
        w_b = sat(w_sum[2]);
      end
      MODE_INVERT: begin
        w_r = ~r_r2;
        w_g = ~r_g2;
        w_b = ~r_b2;
      end
    endcase
  end

  // Output registers only move when a valid pixel advances into them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_r <= '0;
      o_g <= '0;
      o_b <= '0;
    end else if (i_en && i_s2_vld) begin
      o_r <= w_r;
      o_g <= w_g;
      o_b <= w_b;
    end
  end

endmodule

// File: rtl/pixel_filter_engine.sv
// Frame sequencer: reads NUM_PIXELS RGB pixels, filters them and streams them
// out on a valid/ready interface with an address tag and a done pulse.
module pixel_filter_engine
  import pixel_filter_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned NUM_PIXELS = 256,
  parameter int unsigned COEF_W     = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_r,
  input  logic [DATA_W-1:0] mem_g,
  input  logic [DATA_W-1:0] mem_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_r,
  output logic [DATA_W-1:0] out_g,
  output logic [DATA_W-1:0] out_b,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

  state_e            r_state;
  mode_e             r_mode;
  logic              r_issue;
  logic              r_busy;
  logic [ADDR_W-1:0] r_addr;
  logic              r_s1_vld, r_s2_vld, r_out_valid;
  logic [ADDR_W-1:0] r_s1_addr, r_s2_addr, r_out_addr;

  logic w_stall, w_adv, w_done, w_mem_en;

  // A held output freezes the whole pipe, including the memory read.
  assign w_stall  = r_out_valid & ~out_ready;
  assign w_adv    = ~w_stall;
  assign w_mem_en = r_issue & w_adv;
  assign w_done   = r_out_valid & out_ready & (r_out_addr == LAST_ADDR);

  assign mem_en    = w_mem_en;
  assign mem_addr  = r_addr;
  assign out_valid = r_out_valid;
  assign out_addr  = r_out_addr;
  assign busy      = r_busy;
  assign done      = w_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_PASS;
      r_issue <= 1'b0;
      r_busy  <= 1'b0;
      r_addr  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_mode  <= mode_e'(mode);
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
            r_issue <= 1'b1;
            r_addr  <= '0;
          end
        end
        ST_RUN: begin
          if (w_adv) begin
            if (r_addr == LAST_ADDR) begin
              r_issue <= 1'b0;
              r_state <= ST_DRAIN;
            end else begin
              r_addr <= r_addr + ADDR_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (w_done) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Valid and address tag travel alongside the datapath stages.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_vld    <= 1'b0;
      r_s2_vld    <= 1'b0;
      r_out_valid <= 1'b0;
      r_s1_addr   <= '0;
      r_s2_addr   <= '0;
      r_out_addr  <= '0;
    end else if (w_adv) begin
      r_s1_vld    <= r_issue;
      r_s1_addr   <= r_addr;
      r_s2_vld    <= r_s1_vld;
      r_s2_addr   <= r_s1_addr;
      r_out_valid <= r_s2_vld;
      if (r_s2_vld) r_out_addr <= r_s2_addr;
    end
  end

  pixel_filter_math #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W)
  ) u_math (
    .clk      (clk),
    .reset    (reset),
    .i_en     (w_adv),
    .i_s2_vld (r_s2_vld),
    .i_mode   (r_mode),
    .i_r      (mem_r),
    .i_g      (mem_g),
    .i_b      (mem_b),
    .o_r      (out_r),
    .o_g      (out_g),
    .o_b      (out_b)
  );

endmodule
